grid_mover: RTL

GRID_MOVER -- requirements
Module: grid_mover

---
 rtl/grid_mover_pkg.sv | 29 ++
 rtl/grid_mover_tile_neighbor.sv | 35 +++
 rtl/grid_mover.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/grid_mover_pkg.sv
// Shared definitions for the grid movers: direction encodings, FSM states and
// the default playfield geometry.
package grid_mover_pkg;

    typedef enum logic [1:0] {
        dir_up    = 2'd0,
        dir_down  = 2'd1,
        dir_left  = 2'd2,
        dir_right = 2'd3
    } dir_t;

    typedef enum logic {
        STOP = 1'b0,
        MOVE = 1'b1
    } state_t;

    localparam int DEF_TILE_SIZE = 20;
    localparam int DEF_COLS      = 32;
    localparam int DEF_ROWS      = 24;
    localparam int DEF_SPEED     = 4;
    localparam int DEF_WIDTH     = DEF_COLS * DEF_TILE_SIZE;
    localparam int DEF_HEIGHT    = DEF_ROWS * DEF_TILE_SIZE;

    // up/down and left/right differ only in bit 0
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return d ^ 2'b01;
    endfunction

endpackage

// File: rtl/grid_mover_tile_neighbor.sv
// Combinational neighbour lookup: the tile next to (col,row) in direction dir,
// wrapping at the playfield edges, and whether that tile is a wall.
module tile_neighbor
    import grid_mover_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS
) (
    input  logic [$clog2(COLS)-1:0] col,
    input  logic [$clog2(ROWS)-1:0] row,
    input  logic [1:0]              dir,
    input  logic [ROWS*COLS-1:0]    walls,
    output logic                    wall
);

    localparam int IW = $clog2(ROWS * COLS);

    logic [31:0]   nc;
    logic [31:0]   nr;
    logic [IW-1:0] nidx;

    always_comb begin
        nc = 32'(col);
        nr = 32'(row);
        case (dir)
            dir_up:    nr = (nr == 0) ? 32'(ROWS - 1) : nr - 1;
            dir_down:  nr = (nr == 32'(ROWS - 1)) ? 32'd0 : nr + 1;
            dir_left:  nc = (nc == 0) ? 32'(COLS - 1) : nc - 1;
            default:   nc = (nc == 32'(COLS - 1)) ? 32'd0 : nc + 1;
        endcase
        nidx = IW'(nr * 32'(COLS) + nc);
        wall = walls[nidx];
    end

endmodule

// File: rtl/grid_mover.sv
// Tile-grid actor mover: steps SPEED pixels per tick, turns at tile centres,
// reverses anywhere, wraps through tunnels and reports dots it lands on.
//
// state | meaning
// STOP  | blocked by a wall ahead (or idle since reset)
// MOVE  | last step advanced the actor
module grid_mover
    import grid_mover_pkg::*;
#(
    parameter int         TILE_SIZE = DEF_TILE_SIZE,
    parameter int         COLS      = DEF_COLS,
    parameter int         ROWS      = DEF_ROWS,
    parameter int         SPEED     = DEF_SPEED,
    parameter int         START_COL = 1,
    parameter int         START_ROW = 1,
    parameter logic [1:0] START_DIR = dir_left
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 step_en,
    input  logic                                 req_valid,
    input  logic [1:0]                           req_dir,
    input  logic [ROWS*COLS-1:0]                 walls,
    input  logic [ROWS*COLS-1:0]                 dots,
    output logic [$clog2(COLS*TILE_SIZE)-1:0]    x,
    output logic [$clog2(ROWS*TILE_SIZE)-1:0]    y,
    output logic [1:0]                           dir,
    output logic                                 moving,
    output logic                                 eat_valid,
    output logic [$clog2(ROWS*COLS)-1:0]         eat_idx,
    output logic [15:0]                          score
);

    localparam int XW = $clog2(COLS * TILE_SIZE);
    localparam int YW = $clog2(ROWS * TILE_SIZE);
    localparam int IW = $clog2(ROWS * COLS);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int unsigned W_PIX = COLS * TILE_SIZE;
    localparam int unsigned H_PIX = ROWS * TILE_SIZE;
    localparam int unsigned TS    = TILE_SIZE;
    localparam int unsigned SPD   = SPEED;

    state_t        state_q, state_d;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_d;
    logic [1:0]    dir_d, mv_dir;
    logic [1:0]    pend_dir_q, pend_dir_d;
    logic          pend_valid_q, pend_valid_d;
    logic          do_move, moved_q;
    logic [31:0]   xs, ys, nx, ny;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          aligned;
    logic [IW-1:0] cur_idx, last_eat_idx;
    logic          pend_wall, dir_wall;

    assign xs      = 32'(x);
    assign ys      = 32'(y);
    assign col     = CW'(xs / TS);
    assign row     = RW'(ys / TS);
    assign aligned = ((xs % TS) == 0) && ((ys % TS) == 0);
    assign cur_idx = IW'(32'(row) * 32'(COLS) + 32'(col));

    tile_neighbor #(.COLS(COLS), .ROWS(ROWS)) u_pend_nb (
        .col   (col),
        .row   (row),
        .dir   (pend_dir_q),
        .walls (walls),
        .wall  (pend_wall)
    );

    tile_neighbor #(.COLS(COLS), .ROWS(ROWS)) u_dir_nb (
        .col   (col),
        .row   (row),
        .dir   (dir),
        .walls (walls),
        .wall  (dir_wall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= STOP;
            x            <= XW'(START_COL * TILE_SIZE);
            y            <= YW'(START_ROW * TILE_SIZE);
            dir          <= START_DIR;
            pend_valid_q <= 1'b0;
            pend_dir_q   <= START_DIR;
            moved_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            x            <= x_d;
            y            <= y_d;
            dir          <= dir_d;
            pend_valid_q <= pend_valid_d;
            pend_dir_q   <= pend_dir_d;
            moved_q      <= do_move;
        end
    end

    // the step only ever sees the registered pending turn, so a request in the
    // same cycle as step_en waits for the following step
    always_comb begin
        state_d      = state_q;
        dir_d        = dir;
        pend_valid_d = pend_valid_q;
        pend_dir_d   = pend_dir_q;
        mv_dir       = dir;
        do_move      = 1'b0;
        nx           = xs;
        ny           = ys;
        if (step_en) begin
            if (aligned) begin
                if (pend_valid_q && !pend_wall) begin
                    mv_dir       = pend_dir_q;
                    pend_valid_d = 1'b0;
                    do_move      = 1'b1;
                end else if (!dir_wall) begin
                    do_move = 1'b1;
                end
            end else begin
                if (pend_valid_q && (pend_dir_q == opposite_dir(dir))) begin
                    mv_dir       = pend_dir_q;
                    pend_valid_d = 1'b0;
                end
                do_move = 1'b1;
            end
            dir_d   = mv_dir;
            state_d = do_move ? MOVE : STOP;
        end
        if (do_move) begin
            case (mv_dir)
                dir_up:    ny = (ys < SPD) ? ys + H_PIX - SPD : ys - SPD;
                dir_down:  ny = (ys + SPD >= H_PIX) ? ys + SPD - H_PIX : ys + SPD;
                dir_left:  nx = (xs < SPD) ? xs + W_PIX - SPD : xs - SPD;
                default:   nx = (xs + SPD >= W_PIX) ? xs + SPD - W_PIX : xs + SPD;
            endcase
        end
        x_d = XW'(nx);
        y_d = YW'(ny);
        if (req_valid) begin
            pend_valid_d = 1'b1;
            pend_dir_d   = req_dir;
        end
    end

    always_comb begin
        moving = (state_q == MOVE);
    end

    // eat only on arrival at a tile, so standing still never re-triggers
    always_ff @(posedge clk) begin
        if (reset) begin
            eat_valid    <= 1'b0;
            eat_idx      <= '0;
            score        <= 16'd0;
            last_eat_idx <= '1;
        end else begin
            eat_valid <= 1'b0;
            if (moved_q && aligned && dots[cur_idx] && (cur_idx != last_eat_idx)) begin
                eat_valid    <= 1'b1;
                eat_idx      <= cur_idx;
                last_eat_idx <= cur_idx;
                if (score != 16'hFFFF) begin
                    score <= score + 16'd1;
                end
            end
        end
    end

endmodule
